// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder/loader: symbolic ops, RV32I field constants,
// loader error codes and loader states.
package instr_enc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_ADDI = 4'd5,
      OP_ANDI = 4'd6,
      OP_ORI  = 4'd7,
      OP_SLTI = 4'd8,
      OP_LW   = 4'd9,
      OP_SW   = 4'd10,
      OP_BEQ  = 4'd11,
      OP_JAL  = 4'd12
   } instr_op_e;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BEQ  = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;

   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_SLT   = 3'b010;
   localparam logic [2:0] F3_OR    = 3'b110;
   localparam logic [2:0] F3_AND   = 3'b111;
   localparam logic [2:0] F3_WORD  = 3'b010;
   localparam logic [2:0] F3_BEQ   = 3'b000;

   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_SUB   = 7'b0100000;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_OP   = 2'b01,
      ERR_IMM  = 2'b10,
      ERR_OVF  = 2'b11
   } err_code_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_e;

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational symbolic-instruction to RV32I word encoder with immediate range checks.
// Zero latency; no handshake, the loader decides when the result is consumed.
module rv_instr_encoder
   import instr_enc_pkg::*;
(
   input  logic [3:0]  i_Op,
   input  logic [4:0]  i_Rd,
   input  logic [4:0]  i_Rs1,
   input  logic [4:0]  i_Rs2,
   input  logic [31:0] i_Imm,
   output logic [31:0] o_Word,
   output logic        o_Legal,
   output err_code_e   o_ErrCode
);

   logic signed [31:0] w_Imm;
   logic               w_Fit12;
   logic               w_FitBeq;
   logic               w_FitJal;

   assign w_Imm    = $signed(i_Imm);
   assign w_Fit12  = (w_Imm >= -32'sd2048) && (w_Imm <= 32'sd2047);
   // Branch/jump offsets are in bytes but must be halfword aligned.
   assign w_FitBeq = (w_Imm >= -32'sd4096) && (w_Imm <= 32'sd4094) && !i_Imm[0];
   assign w_FitJal = (w_Imm >= -32'sd1048576) && (w_Imm <= 32'sd1048574) && !i_Imm[0];

   always_comb begin
      o_Word    = 32'h0;
      o_Legal   = 1'b1;
      o_ErrCode = ERR_NONE;
      case (i_Op)
         OP_ADD:  o_Word = {F7_BASE, i_Rs2, i_Rs1, F3_ADD, i_Rd, OPC_R};
         OP_SUB:  o_Word = {F7_SUB,  i_Rs2, i_Rs1, F3_ADD, i_Rd, OPC_R};
         OP_AND:  o_Word = {F7_BASE, i_Rs2, i_Rs1, F3_AND, i_Rd, OPC_R};
         OP_OR:   o_Word = {F7_BASE, i_Rs2, i_Rs1, F3_OR,  i_Rd, OPC_R};
         OP_SLT:  o_Word = {F7_BASE, i_Rs2, i_Rs1, F3_SLT, i_Rd, OPC_R};
         OP_ADDI: o_Word = {i_Imm[11:0], i_Rs1, F3_ADD, i_Rd, OPC_I};
         OP_ANDI: o_Word = {i_Imm[11:0], i_Rs1, F3_AND, i_Rd, OPC_I};
         OP_ORI:  o_Word = {i_Imm[11:0], i_Rs1, F3_OR,  i_Rd, OPC_I};
         OP_SLTI: o_Word = {i_Imm[11:0], i_Rs1, F3_SLT, i_Rd, OPC_I};
         OP_LW:   o_Word = {i_Imm[11:0], i_Rs1, F3_WORD, i_Rd, OPC_LW};
         OP_SW:   o_Word = {i_Imm[11:5], i_Rs2, i_Rs1, F3_WORD, i_Imm[4:0], OPC_SW};
         OP_BEQ:  o_Word = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, F3_BEQ,
                            i_Imm[4:1], i_Imm[11], OPC_BEQ};
         OP_JAL:  o_Word = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], i_Rd, OPC_JAL};
         default: begin
            o_Legal   = 1'b0;
            o_ErrCode = ERR_OP;
         end
      endcase

      if (o_Legal) begin
         if (((i_Op >= OP_ADDI) && (i_Op <= OP_SW) && !w_Fit12) ||
             ((i_Op == OP_BEQ) && !w_FitBeq) ||
             ((i_Op == OP_JAL) && !w_FitJal)) begin
            o_Word    = 32'h0;
            o_Legal   = 1'b0;
            o_ErrCode = ERR_IMM;
         end
      end
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: encodes one instruction per accepted handshake and writes it one cycle later.
// o_Ready drops outside LOAD and once memory is full; the core is held in reset until DONE.
module instr_encode_loader
   import instr_enc_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0
)
(
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic        i_Start,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic [3:0]  i_Op,
   input  logic [4:0]  i_Rd,
   input  logic [4:0]  i_Rs1,
   input  logic [4:0]  i_Rs2,
   input  logic [31:0] i_Imm,
   input  logic        i_Last,
   output logic        o_IMemWE,
   output logic [31:0] o_IMemAddr,
   output logic [31:0] o_IMemWData,
   output logic        o_CoreReset_n,
   output logic        o_Done,
   output logic        o_Error,
   output logic [1:0]  o_ErrCode
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e        r_State;
   state_e        w_NextState;
   logic [CW-1:0] r_Count;
   logic          r_WE;
   logic [31:0]   r_Addr;
   logic [31:0]   r_WData;
   logic          r_Done;
   logic          r_Error;
   err_code_e     r_ErrCode;

   logic [31:0]   w_Word;
   logic          w_Legal;
   err_code_e     w_EncErr;
   logic          w_Xfer;
   logic          w_Full;

   rv_instr_encoder u_encoder (
      .i_Op      (i_Op),
      .i_Rd      (i_Rd),
      .i_Rs1     (i_Rs1),
      .i_Rs2     (i_Rs2),
      .i_Imm     (i_Imm),
      .o_Word    (w_Word),
      .o_Legal   (w_Legal),
      .o_ErrCode (w_EncErr)
   );

   assign o_Ready = (r_State == S_LOAD) && (r_Count < CW'(DEPTH));
   assign w_Xfer  = i_Valid & o_Ready;
   // The word being accepted now occupies the last memory slot.
   assign w_Full  = (r_Count == CW'(DEPTH - 1));

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) r_State <= S_IDLE;
      else            r_State <= w_NextState;
   end

   always_comb begin
      w_NextState = r_State;
      case (r_State)
         S_LOAD: begin
            if (w_Xfer) begin
               if (!w_Legal)    w_NextState = S_ERROR;
               else if (i_Last) w_NextState = S_DONE;
               else if (w_Full) w_NextState = S_ERROR;
            end
         end
         default: if (i_Start) w_NextState = S_LOAD;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         r_Count   <= '0;
         r_WE      <= 1'b0;
         r_Addr    <= BASE_ADDR;
         r_WData   <= 32'h0;
         r_Done    <= 1'b0;
         r_Error   <= 1'b0;
         r_ErrCode <= ERR_NONE;
      end else begin
         r_WE   <= 1'b0;
         // Done lags DONE entry by a cycle so the final write lands before the core runs.
         r_Done <= (r_State == S_DONE) && (w_NextState == S_DONE);
         if ((r_State != S_LOAD) && i_Start) begin
            r_Count   <= '0;
            r_Error   <= 1'b0;
            r_ErrCode <= ERR_NONE;
         end else if (w_Xfer) begin
            if (w_Legal) begin
               r_WE    <= 1'b1;
               r_Addr  <= BASE_ADDR + (32'(r_Count) << 2);
               r_WData <= w_Word;
               r_Count <= r_Count + 1'b1;
               if (!i_Last && w_Full) begin
                  r_Error   <= 1'b1;
                  r_ErrCode <= ERR_OVF;
               end
            end else begin
               r_Error   <= 1'b1;
               r_ErrCode <= w_EncErr;
            end
         end
      end
   end

   assign o_IMemWE      = r_WE;
   assign o_IMemAddr    = r_Addr;
   assign o_IMemWData   = r_WData;
   assign o_Done        = r_Done;
   assign o_CoreReset_n = r_Done;
   assign o_Error       = r_Error;
   assign o_ErrCode     = r_ErrCode;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encodings, handshake timing, errors, overflow, reset.
module tb_instr_encode_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, start_b;
   logic        valid;
   logic [3:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        last;

   logic        ready, we, core_rst_n, done, error;
   logic [31:0] addr, wdata;
   logic [1:0]  errcode;

   logic        b_ready, b_we, b_core_rst_n, b_done, b_error;
   logic [31:0] b_addr, b_wdata;
   logic [1:0]  b_errcode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_encode_loader #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_Valid(valid), .o_Ready(ready),
      .i_Op(op), .i_Rd(rd), .i_Rs1(rs1), .i_Rs2(rs2), .i_Imm(imm), .i_Last(last),
      .o_IMemWE(we), .o_IMemAddr(addr), .o_IMemWData(wdata), .o_CoreReset_n(core_rst_n),
      .o_Done(done), .o_Error(error), .o_ErrCode(errcode)
   );

   instr_encode_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut_small (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start_b), .i_Valid(valid), .o_Ready(b_ready),
      .i_Op(op), .i_Rd(rd), .i_Rs1(rs1), .i_Rs2(rs2), .i_Imm(imm), .i_Last(last),
      .o_IMemWE(b_we), .o_IMemAddr(b_addr), .o_IMemWData(b_wdata), .o_CoreReset_n(b_core_rst_n),
      .o_Done(b_done), .o_Error(b_error), .o_ErrCode(b_errcode)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for exactly one edge, then drop valid.
   task automatic xfer(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic l);
      valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
      tick();
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_b = 1'b0; valid = 1'b0;
      op = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0; last = 1'b0;
      tick(); tick();

      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_we", {31'h0, we}, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_corerst", {31'h0, core_rst_n}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {29'h0, error, errcode}, 32'h0);

      rst_n = 1'b1;
      tick();
      chk("idle_ready", {31'h0, ready}, 32'h0);
      do_start();
      chk("load_ready", {31'h0, ready}, 32'h1);
      chk("load_we_idle", {31'h0, we}, 32'h0);

      // Back-to-back program ending in a branch.
      xfer(4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
      chk("add_we", {31'h0, we}, 32'h1);
      chk("add_addr", addr, 32'h0);
      chk("add_data", wdata, 32'h002081B3);
      xfer(4'd1, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);
      chk("sub_addr", addr, 32'h4);
      chk("sub_data", wdata, 32'h407302B3);
      xfer(4'd9, 5'd5, 5'd0, 5'd0, -32'sd4, 1'b0);
      chk("lw_addr", addr, 32'h8);
      chk("lw_data", wdata, 32'hFFC02283);
      xfer(4'd10, 5'd0, 5'd0, 5'd5, 32'd8, 1'b0);
      chk("sw_addr", addr, 32'hC);
      chk("sw_data", wdata, 32'h00502423);
      xfer(4'd11, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1);
      chk("beq_we", {31'h0, we}, 32'h1);
      chk("beq_addr", addr, 32'h10);
      chk("beq_data", wdata, 32'hFE208CE3);
      chk("beq_done_early", {31'h0, done}, 32'h0);
      chk("beq_ready", {31'h0, ready}, 32'h0);
      tick();
      chk("done_we", {31'h0, we}, 32'h0);
      chk("done", {31'h0, done}, 32'h1);
      chk("done_corerst", {31'h0, core_rst_n}, 32'h1);
      chk("done_ready", {31'h0, ready}, 32'h0);
      tick();
      chk("done_hold", {31'h0, done}, 32'h1);

      // Restart from DONE: count clears, core back in reset.
      do_start();
      chk("restart_done", {31'h0, done}, 32'h0);
      chk("restart_corerst", {31'h0, core_rst_n}, 32'h0);
      xfer(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      chk("addi_addr", addr, 32'h0);
      chk("addi_data", wdata, 32'hFFF00093);
      xfer(4'd2, 5'd4, 5'd2, 5'd3, 32'h0, 1'b0);
      chk("and_data", wdata, 32'h00317233);
      xfer(4'd8, 5'd2, 5'd1, 5'd0, 32'd5, 1'b0);
      chk("slti_data", wdata, 32'h0050A113);
      xfer(4'd12, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
      chk("jal_addr", addr, 32'hC);
      chk("jal_data", wdata, 32'h001000EF);
      xfer(4'd5, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
      chk("addi_rng_we", {31'h0, we}, 32'h0);
      chk("addi_rng_err", {29'h0, error, errcode}, 32'h6);
      chk("addi_rng_ready", {31'h0, ready}, 32'h0);
      chk("addi_rng_corerst", {31'h0, core_rst_n}, 32'h0);

      do_start();
      chk("err_cleared", {29'h0, error, errcode}, 32'h0);
      xfer(4'd11, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
      chk("beq_align_we", {31'h0, we}, 32'h0);
      chk("beq_align_err", {29'h0, error, errcode}, 32'h6);
      chk("beq_align_done", {31'h0, done}, 32'h0);

      do_start();
      xfer(4'd14, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0);
      chk("badop_we", {31'h0, we}, 32'h0);
      chk("badop_err", {29'h0, error, errcode}, 32'h5);
      chk("badop_corerst", {31'h0, core_rst_n}, 32'h0);
      tick();
      chk("badop_hold", {29'h0, error, errcode}, 32'h5);

      // Overflow on the 4-deep instance.
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("small_ready", {31'h0, b_ready}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         xfer(4'd5, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
         chk($sformatf("small_we%0d", i), {31'h0, b_we}, 32'h1);
         chk($sformatf("small_addr%0d", i), b_addr, 32'(4 * i));
         chk($sformatf("small_data%0d", i), b_wdata,
             {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011});
      end
      chk("small_full_ready", {31'h0, b_ready}, 32'h0);
      tick();
      chk("small_ovf_we", {31'h0, b_we}, 32'h0);
      chk("small_ovf_err", {29'h0, b_error, b_errcode}, 32'h7);
      chk("small_ovf_done", {30'h0, b_done, b_core_rst_n}, 32'h0);

      // Reset in the middle of a session.
      do_start();
      xfer(4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
      chk("mid_we", {31'h0, we}, 32'h1);
      valid = 1'b1; op = 4'd1; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd7;
      rst_n = 1'b0;
      tick();
      valid = 1'b0;
      chk("mid_rst_we", {31'h0, we}, 32'h0);
      chk("mid_rst_addr", addr, 32'h0);
      chk("mid_rst_wdata", wdata, 32'h0);
      chk("mid_rst_ready", {31'h0, ready}, 32'h0);
      chk("mid_rst_flags", {28'h0, done, core_rst_n, error, 1'b0} | {30'h0, errcode}, 32'h0);
      rst_n = 1'b1;
      tick();
      do_start();
      xfer(4'd3, 5'd9, 5'd4, 5'd8, 32'h0, 1'b0);
      chk("post_rst_addr", addr, 32'h0);
      chk("post_rst_data", wdata, 32'h008264B3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
